// File: rtl/imem_loader.sv
// imem_loader
// Byte-stream program loader that fills the instruction RAM the core fetches
// from. The loader receives a frame from a UART-style receiver. The frame is
// LEN_LO, LEN_HI, then 4*N data bytes (little-endian words), then one XOR
// checksum byte that covers the data bytes only. Each assembled word is
// written to consecutive word addresses starting at 0. The core is held in
// reset until a load completes with a matching checksum.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   start         one-cycle pulse that begins a load (only in IDLE/DONE_S/ERR)
//   rx_data       byte from the receiver
//   rx_valid      rx_data is valid
//   rx_ready      loader accepts a byte (transfer = rx_valid & rx_ready)
//   mem_we        instruction-memory write strobe, one cycle per word
//   mem_address   word address of the write
//   mem_data      word to write
//   cpu_hold      high keeps the core in reset
//   busy          load in progress
//   done          last load succeeded (sticky until start/reset)
//   error         last load failed (sticky until start/reset)
//   words_written words written in the current or last load
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE_S, ERR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       n_q, n_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        xor_q, xor_d;
  logic              rx_ready_q, rx_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ADDR_W:0]   words_written_q, words_written_d;

  logic              xfer;
  logic [15:0]       len_word;

  assign xfer     = rx_valid && rx_ready_q;
  assign len_word = {rx_data, len_lo_q};

  always_comb begin
    state_d         = state_q;
    len_lo_d        = len_lo_q;
    n_d             = n_q;
    byte_idx_d      = byte_idx_q;
    word_d          = word_q;
    xor_d           = xor_q;
    mem_address_d   = mem_address_q;
    mem_data_d      = mem_data_q;
    cpu_hold_d      = cpu_hold_q;
    busy_d          = busy_q;
    done_d          = done_q;
    error_d         = error_q;
    words_written_d = words_written_q;

    case (state_q)
      IDLE, DONE_S, ERR: begin
        if (start) begin
          state_d         = LEN_LO;
          busy_d          = 1'b1;
          cpu_hold_d      = 1'b1;
          done_d          = 1'b0;
          error_d         = 1'b0;
          words_written_d = '0;
          byte_idx_d      = '0;
          xor_d           = '0;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_lo_d = rx_data;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          n_d = len_word;
          if (len_word == 16'd0) begin
            state_d = CHECK;
          end else if (32'(len_word) > DEPTH) begin
            // Oversized image: fail at once and leave the rest of the frame unread.
            state_d = ERR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
          xor_d      = xor_q ^ rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // The write outputs are loaded here so they are registered during WRITE.
            state_d       = WRITE;
            mem_address_d = words_written_q[ADDR_W-1:0];
            mem_data_d    = word_d;
          end
        end
      end
      WRITE: begin
        words_written_d = words_written_q + 1'b1;
        if (16'(words_written_d) == n_q) begin
          state_d = CHECK;
        end else begin
          state_d = DATA;
        end
      end
      CHECK: begin
        if (xfer) begin
          busy_d = 1'b0;
          if (rx_data == xor_q) begin
            state_d    = DONE_S;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake and strobe follow the state being entered so they are registered.
    rx_ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) ||
                 (state_d == DATA)   || (state_d == CHECK);
    mem_we_d   = (state_d == WRITE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      len_lo_q        <= '0;
      n_q             <= '0;
      byte_idx_q      <= '0;
      word_q          <= '0;
      xor_q           <= '0;
      rx_ready_q      <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_address_q   <= '0;
      mem_data_q      <= '0;
      cpu_hold_q      <= 1'b1;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      words_written_q <= '0;
    end else begin
      state_q         <= state_d;
      len_lo_q        <= len_lo_d;
      n_q             <= n_d;
      byte_idx_q      <= byte_idx_d;
      word_q          <= word_d;
      xor_q           <= xor_d;
      rx_ready_q      <= rx_ready_d;
      mem_we_q        <= mem_we_d;
      mem_address_q   <= mem_address_d;
      mem_data_q      <= mem_data_d;
      cpu_hold_q      <= cpu_hold_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      error_q         <= error_d;
      words_written_q <= words_written_d;
    end
  end

  assign rx_ready      = rx_ready_q;
  assign mem_we        = mem_we_q;
  assign mem_address   = mem_address_q;
  assign mem_data      = mem_data_q;
  assign cpu_hold      = cpu_hold_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_written = words_written_q;

endmodule
